// File: rtl/cpu_8bit_pkg.sv
// Shared types for the register-file controller: command opcodes and the
// controller FSM state encoding.
package cpu_8bit_pkg;

    // Command opcodes carried on i_op
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_SWAP  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWAP2 = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_regfile_mem.sv
// Register storage: NUM_REGS x DATA_W flops with one write port, a
// synchronous clear, and three combinational read ports. Addresses at or
// beyond NUM_REGS read as zero and never write.
module cpu_regfile_mem #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 4,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    input  logic [ADDR_W-1:0] i_raddr_c,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_c
);

    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    logic [DATA_W-1:0] w_regs  [NUM_REGS];
    logic [ADDR_W-1:0] w_raddr [3];
    logic [DATA_W-1:0] w_rdata [3];

    assign w_raddr[0] = i_raddr_a;
    assign w_raddr[1] = i_raddr_b;
    assign w_raddr[2] = i_raddr_c;

    assign o_rdata_a = w_rdata[0];
    assign o_rdata_b = w_rdata[1];
    assign o_rdata_c = w_rdata[2];

    genvar gi;

    // One storage register per address; clear beats write
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_val;

            // Per-register update: reset, clear, or addressed write
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_val <= '0;
                end else if (i_clr) begin
                    r_val <= '0;
                end else if (i_we && (i_waddr == ADDR_W'(gi))) begin
                    r_val <= i_wdata;
                end
            end

            assign w_regs[gi] = r_val;
        end
    endgenerate

    // Read ports return zero for addresses outside the register file
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rport
            assign w_rdata[gi] = ({1'b0, w_raddr[gi]} < NUM_REGS_W)
                               ? w_regs[w_raddr[gi]] : '0;
        end
    endgenerate

endmodule

// File: rtl/cpu_regfile_ctrl.sv
// Register-file command controller. Accepts WRITE/READ/SWAP/CLEAR commands
// in IDLE, executes them against cpu_regfile_mem and acknowledges in RESP.
// Optional macro CPU_REGFILE_BYPASS_EN forwards in-flight WRITE data to the
// ALU operand ports during EXEC.
module cpu_regfile_ctrl
    import cpu_8bit_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 4,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [1:0]        i_op,
    input  logic [ADDR_W-1:0] i_addr_x,
    input  logic [ADDR_W-1:0] i_addr_y,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_sel_a,
    input  logic [ADDR_W-1:0] i_sel_b,
    output logic [DATA_W-1:0] o_opa,
    output logic [DATA_W-1:0] o_opb,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_bus_oe,
    output logic              o_ack,
    output logic              o_busy
);

    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    state_e            r_state;
    state_e            w_state_next;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr_x;
    logic [ADDR_W-1:0] r_addr_y;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_ydata;
    logic [DATA_W-1:0] r_tmp;
    logic [DATA_W-1:0] r_rdata;

    logic              w_x_ok;
    logic              w_y_ok;
    logic              w_mem_we;
    logic              w_mem_clr;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [ADDR_W-1:0] w_port_c_addr;
    logic [DATA_W-1:0] w_port_c_data;
    logic [DATA_W-1:0] w_mem_opa;
    logic [DATA_W-1:0] w_mem_opb;

    assign w_x_ok = ({1'b0, r_addr_x} < NUM_REGS_W);
    assign w_y_ok = ({1'b0, r_addr_y} < NUM_REGS_W);

    // The control read port prefetches reg[y] while idle (used by SWAP), and
    // reads reg[x] during EXEC for READ and for the SWAP temporary. Only the
    // controller writes the file, so the prefetched value is still current.
    assign w_port_c_addr = (r_state == IDLE) ? i_addr_y : r_addr_x;

    cpu_regfile_mem #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_mem_clr),
        .i_we      (w_mem_we),
        .i_waddr   (w_mem_waddr),
        .i_wdata   (w_mem_wdata),
        .i_raddr_a (i_sel_a),
        .i_raddr_b (i_sel_b),
        .i_raddr_c (w_port_c_addr),
        .o_rdata_a (w_mem_opa),
        .o_rdata_b (w_mem_opb),
        .o_rdata_c (w_port_c_data)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = i_req ? EXEC : IDLE;
            EXEC:    w_state_next = (r_op == OP_SWAP) ? SWAP2 : RESP;
            SWAP2:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake and status flags
    always_comb begin
        o_ack    = 1'b0;
        o_bus_oe = 1'b0;
        o_busy   = (r_state != IDLE);
        if (r_state == RESP) begin
            o_ack    = 1'b1;
            o_bus_oe = (r_op == OP_READ);
        end
    end

    // Register-file write steering; a SWAP with any bad address is a no-op
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_clr   = 1'b0;
        w_mem_waddr = r_addr_x;
        w_mem_wdata = r_wdata;
        case (r_state)
            EXEC: begin
                case (r_op)
                    OP_WRITE: w_mem_we = w_x_ok;
                    OP_SWAP: begin
                        w_mem_we    = w_x_ok && w_y_ok;
                        w_mem_wdata = r_ydata;
                    end
                    OP_CLEAR: w_mem_clr = 1'b1;
                    default:  w_mem_we  = 1'b0;
                endcase
            end
            SWAP2: begin
                w_mem_we    = w_x_ok && w_y_ok;
                w_mem_waddr = r_addr_y;
                w_mem_wdata = r_tmp;
            end
            default: w_mem_we = 1'b0;
        endcase
    end

    // Command latch, SWAP temporary and registered READ result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op     <= OP_WRITE;
            r_addr_x <= '0;
            r_addr_y <= '0;
            r_wdata  <= '0;
            r_ydata  <= '0;
            r_tmp    <= '0;
            r_rdata  <= '0;
        end else begin
            if ((r_state == IDLE) && i_req) begin
                r_op     <= op_e'(i_op);
                r_addr_x <= i_addr_x;
                r_addr_y <= i_addr_y;
                r_wdata  <= i_wdata;
                r_ydata  <= w_port_c_data;
            end
            if (r_state == EXEC) begin
                if (r_op == OP_READ) begin
                    r_rdata <= w_port_c_data;
                end
                if (r_op == OP_SWAP) begin
                    r_tmp <= w_port_c_data;
                end
            end
        end
    end

    assign o_rdata = r_rdata;

`ifdef CPU_REGFILE_BYPASS_EN
    logic w_byp;

    // Forward the pending WRITE data to operands that select its address
    always_comb begin
        w_byp = (r_state == EXEC) && (r_op == OP_WRITE) && w_x_ok;
        o_opa = (w_byp && (i_sel_a == r_addr_x)) ? r_wdata : w_mem_opa;
        o_opb = (w_byp && (i_sel_b == r_addr_x)) ? r_wdata : w_mem_opb;
    end
`else
    // Operands show committed register contents only
    always_comb begin
        o_opa = w_mem_opa;
        o_opb = w_mem_opb;
    end
`endif

endmodule

// File: tb/tb_cpu_regfile_ctrl.sv
// Scoreboard bench for cpu_regfile_ctrl. Expected completions are queued when
// a command is accepted and retired by the monitor on each o_ack.
module tb_cpu_regfile_ctrl;

    localparam int DATA_W = 8;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_req = 1'b0;
    logic [1:0] i_op = 2'd0;
    logic [1:0] i_addr_x = '0;
    logic [1:0] i_addr_y = '0;
    logic [7:0] i_wdata = '0;
    logic [1:0] i_sel_a = '0;
    logic [1:0] i_sel_b = '0;
    logic [7:0] o_opa;
    logic [7:0] o_opb;
    logic [7:0] o_rdata;
    logic       o_bus_oe;
    logic       o_ack;
    logic       o_busy;

    typedef struct {
        int unsigned acc_cyc;
        int unsigned lat;
        bit          is_read;
        logic [7:0]  rdata;
        logic [1:0]  op;
    } sb_t;

    sb_t         sb_q[$];
    logic [7:0]  model [4];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          prev_ack = 1'b0;

    cpu_regfile_ctrl #(
        .DATA_W   (DATA_W),
        .NUM_REGS (4)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_op     (i_op),
        .i_addr_x (i_addr_x),
        .i_addr_y (i_addr_y),
        .i_wdata  (i_wdata),
        .i_sel_a  (i_sel_a),
        .i_sel_b  (i_sel_b),
        .o_opa    (o_opa),
        .o_opb    (o_opb),
        .o_rdata  (o_rdata),
        .o_bus_oe (o_bus_oe),
        .o_ack    (o_ack),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: retire scoreboard entries on each acknowledge
    always @(negedge clk) begin
        sb_t e;
        if (prev_ack) begin
            check("ack_one_cycle", {31'd0, o_ack}, 32'd0);
            check("oe_after_resp", {31'd0, o_bus_oe}, 32'd0);
        end
        prev_ack = o_ack;
        if (o_ack) begin
            if (sb_q.size() == 0) begin
                check("spurious_ack", {31'd0, o_ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ack_latency", cyc - e.acc_cyc, e.lat);
                check("bus_oe", {31'd0, o_bus_oe}, {31'd0, e.is_read});
                if (e.is_read) check("rdata", {24'd0, o_rdata}, {24'd0, e.rdata});
                $display("txn op=%0d lat=%0d rdata=%02h oe=%0d", e.op, cyc - e.acc_cyc, o_rdata, o_bus_oe);
            end
        end else if (!prev_ack) begin
            check("oe_without_ack", {31'd0, o_bus_oe}, 32'd0);
        end
    end

    // Drive one command, update the reference model, queue its completion
    task automatic issue(input logic [1:0] op, input logic [1:0] x, input logic [1:0] y,
                         input logic [7:0] wd);
        sb_t        e;
        logic [7:0] t;
        @(negedge clk);
        i_req = 1'b1; i_op = op; i_addr_x = x; i_addr_y = y; i_wdata = wd;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        e.acc_cyc = cyc;
        e.lat     = (op == 2'd2) ? 2 : 1;
        e.is_read = (op == 2'd1);
        e.rdata   = model[x];
        e.op      = op;
        case (op)
            2'd0: model[x] = wd;
            2'd2: begin t = model[x]; model[x] = model[y]; model[y] = t; end
            2'd3: for (int i = 0; i < 4; i++) model[i] = '0;
            default: t = '0;
        endcase
        sb_q.push_back(e);
    endtask

    // Wait for the scoreboard to drain, bounded
    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) return;
        end
        check("ack_timeout", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    // Compare both operand ports against the model for one register
    task automatic check_reg(input string tag, input logic [1:0] r);
        i_sel_a = r;
        i_sel_b = r;
        #1;
        check({tag, "_opa"}, {24'd0, o_opa}, {24'd0, model[r]});
        check({tag, "_opb"}, {24'd0, o_opb}, {24'd0, model[r]});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit [3:0] busy_pat;
        for (int i = 0; i < 4; i++) model[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_ack", {31'd0, o_ack}, 32'd0);
        check("rst_rdata", {24'd0, o_rdata}, 32'd0);
        i_rst = 1'b0;

        // Two writes, then operand readback
        issue(2'd0, 2'd0, 2'd0, 8'hA5); wait_done();
        issue(2'd0, 2'd1, 2'd0, 8'h5A); wait_done();
        i_sel_a = 2'd0; i_sel_b = 2'd1; #1;
        check("opa_reg0", {24'd0, o_opa}, 32'hA5);
        check("opb_reg1", {24'd0, o_opb}, 32'h5A);

        // READ
        issue(2'd1, 2'd1, 2'd0, 8'h00); wait_done();

        // SWAP 0,1 with busy profile EXEC/SWAP2/RESP then IDLE
        issue(2'd2, 2'd0, 2'd1, 8'h00);
        busy_pat = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("swap_busy", {31'd0, o_busy}, {31'd0, busy_pat[k]});
        end
        wait_done();
        i_sel_a = 2'd0; i_sel_b = 2'd1; #1;
        check("swap_reg0", {24'd0, o_opa}, 32'h5A);
        check("swap_reg1", {24'd0, o_opb}, 32'hA5);

        // SWAP with x == y
        issue(2'd0, 2'd2, 2'd0, 8'h77); wait_done();
        issue(2'd2, 2'd2, 2'd2, 8'h00); wait_done();
        i_sel_a = 2'd2; #1;
        check("swap_same", {24'd0, o_opa}, 32'h77);

        // Request during busy is ignored
        issue(2'd1, 2'd2, 2'd0, 8'h00);
        i_req = 1'b1; i_op = 2'd0; i_addr_x = 2'd3; i_wdata = 8'hFF;
        @(posedge clk); @(posedge clk); #1;
        i_req = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        i_sel_a = 2'd3; #1;
        check("busy_ignored", {24'd0, o_opa}, 32'h00);

        // Reset during SWAP2 aborts the swap
        issue(2'd2, 2'd0, 2'd1, 8'h00);
        @(posedge clk);
        #1 i_rst = 1'b1;
        #1;
        sb_q.delete();
        for (int i = 0; i < 4; i++) model[i] = '0;
        check("midrst_ack", {31'd0, o_ack}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_oe", {31'd0, o_bus_oe}, 32'd0);
        check("midrst_rdata", {24'd0, o_rdata}, 32'd0);
        check_reg("midrst_r0", 2'd0);
        check_reg("midrst_r1", 2'd1);
        check_reg("midrst_r2", 2'd2);
        @(negedge clk);
        i_rst = 1'b0;
        issue(2'd0, 2'd1, 2'd0, 8'h3C); wait_done();
        i_sel_b = 2'd1; #1;
        check("post_rst_write", {24'd0, o_opb}, 32'h3C);

        // Load, read, clear
        issue(2'd0, 2'd0, 2'd0, 8'h11); wait_done();
        issue(2'd0, 2'd1, 2'd0, 8'h22); wait_done();
        issue(2'd0, 2'd2, 2'd0, 8'h33); wait_done();
        issue(2'd0, 2'd3, 2'd0, 8'h44); wait_done();
        check_reg("load_r3", 2'd3);
        issue(2'd1, 2'd2, 2'd0, 8'h00); wait_done();
        issue(2'd3, 2'd0, 2'd0, 8'h00); wait_done();
        for (int r = 0; r < 4; r++) begin
            i_sel_a = r[1:0]; i_sel_b = r[1:0]; #1;
            check("clear_opa", {24'd0, o_opa}, 32'h00);
            check("clear_opb", {24'd0, o_opb}, 32'h00);
        end
        issue(2'd1, 2'd3, 2'd0, 8'h00); wait_done();

        // Operand visibility of an in-flight WRITE
        i_sel_a = 2'd0;
        issue(2'd0, 2'd0, 2'd0, 8'hC3);
        @(negedge clk);
`ifdef CPU_REGFILE_BYPASS_EN
        check("exec_opa", {24'd0, o_opa}, 32'hC3);
`else
        check("exec_opa", {24'd0, o_opa}, 32'h00);
`endif
        @(negedge clk);
        check("resp_opa", {24'd0, o_opa}, 32'hC3);
        wait_done();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
